button_bank: RTL and testbench

Parametrised N-channel button front end: synchronises, debounces and classifies raw pushbutton inputs (blinkers, headlight, horn, brake, mode keys). Every channel reports a clean level, single-cycle press/release/long-press events and an optional latched toggle state. It replaces the per-button debouncer instances in the SmartBike top level. Its outputs feed the blinker, brake-light, horn and cell-phone protocol logic.

---
 rtl/smartbike_pkg.sv | 14 +
 rtl/button_channel.sv | 122 ++++++++++++
 rtl/button_bank.sv | 46 ++++
 tb/tb_button_bank.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/smartbike_pkg.sv
// Shared types and timing constants for the SmartBike button front end.
// The button FSM state enum lives here so every channel agrees on the encoding.
package smartbike_pkg;

    typedef enum logic [1:0] {
        BTN_RELEASED,
        BTN_PRESSED,
        BTN_LONG
    } btn_state_t;

    localparam int DEBOUNCE_10MS_AT_50M = 500_000;
    localparam int LONG_PRESS_1S_AT_50M = 50_000_000;

endpackage

// File: rtl/button_channel.sv
// One pushbutton channel: 2-flop synchroniser, debounce counter, press FSM and toggle latch.
// Long-press detection is compiled in only when BUTTON_BANK_LONG_PRESS_EN is defined.
module button_channel
    import smartbike_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES   = DEBOUNCE_10MS_AT_50M,
    parameter int LONG_PRESS_CYCLES = LONG_PRESS_1S_AT_50M,
    parameter bit ACTIVE_LOW        = 1'b1,
    parameter bit TOGGLE            = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic pin,
    input  logic clear_toggle,
    output logic level,
    output logic pressed,
    output logic released,
    output logic long_press,
    output logic toggled
);

    if (DEBOUNCE_CYCLES < 1 || LONG_PRESS_CYCLES < 1) begin : g_bad_cfg
        $error("button_channel: DEBOUNCE_CYCLES and LONG_PRESS_CYCLES must be >= 1");
    end

    localparam int              DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    logic            sync0;
    logic            sync1;
    logic            raw;
    logic [DB_W-1:0] db_cnt;
    logic            accept_press;
    logic            accept_release;

    assign raw            = sync1 ^ ACTIVE_LOW;
    assign accept_press   = raw && !level && (db_cnt == DB_LAST);
    assign accept_release = !raw && level && (db_cnt == DB_LAST);

    // Sync flops reset to the idle pin level so raw reads "not pressed" right after reset.
    always_ff @(posedge clk) begin
        // NOTE: every sequential assignment is non-blocking so all flops sample pre-edge values.
        if (reset) begin
            sync0    <= ACTIVE_LOW;
            sync1    <= ACTIVE_LOW;
            db_cnt   <= '0;
            level    <= 1'b0;
            pressed  <= 1'b0;
            released <= 1'b0;
        end else begin
            sync0    <= pin;
            sync1    <= sync0;
            pressed  <= accept_press;
            released <= accept_release;
            if (raw == level) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                db_cnt <= '0;
                level  <= raw;
            end else begin
                db_cnt <= db_cnt + DB_W'(1);
            end
        end
    end

    // Clear beats a coincident press; non-toggle channels stay at 0.
    always_ff @(posedge clk) begin
        if (reset || clear_toggle || !TOGGLE) begin
            toggled <= 1'b0;
        end else if (pressed) begin
            toggled <= ~toggled;
        end
    end

`ifdef BUTTON_BANK_LONG_PRESS_EN
    localparam int                HOLD_W    = $clog2(LONG_PRESS_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);

    btn_state_t        state;
    logic [HOLD_W-1:0] hold_cnt;

    // Hold count runs from the accepted press; it saturates in LONG so the event fires once.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= BTN_RELEASED;
            hold_cnt   <= '0;
            long_press <= 1'b0;
        end else begin
            long_press <= 1'b0;
            case (state)
                BTN_RELEASED: begin
                    if (accept_press) begin
                        state    <= BTN_PRESSED;
                        hold_cnt <= '0;
                    end
                end
                BTN_PRESSED: begin
                    if (accept_release) begin
                        state <= BTN_RELEASED;
                    end else if (hold_cnt == HOLD_LAST) begin
                        state      <= BTN_LONG;
                        hold_cnt   <= hold_cnt + HOLD_W'(1);
                        long_press <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end
                BTN_LONG: begin
                    if (accept_release) begin
                        state <= BTN_RELEASED;
                    end
                end
                default: state <= BTN_RELEASED;
            endcase
        end
    end
`else
    // Without long-press support the debounced level alone carries the press state.
    assign long_press = 1'b0;
`endif

endmodule

// File: rtl/button_bank.sv
// N-channel button front end: one button_channel per pin, all channels independent.
// Define BUTTON_BANK_LONG_PRESS_EN to enable the long_press events.
module button_bank
    import smartbike_pkg::*;
#(
    parameter int              NUM_CH            = 4,
    parameter int              DEBOUNCE_CYCLES   = DEBOUNCE_10MS_AT_50M,
    parameter int              LONG_PRESS_CYCLES = LONG_PRESS_1S_AT_50M,
    parameter logic [NUM_CH-1:0] ACTIVE_LOW      = '1,
    parameter logic [NUM_CH-1:0] TOGGLE_MASK     = '0
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic [NUM_CH-1:0] buttons,
    input  logic [NUM_CH-1:0] clear_toggle,
    output logic [NUM_CH-1:0] level,
    output logic [NUM_CH-1:0] pressed,
    output logic [NUM_CH-1:0] released,
    output logic [NUM_CH-1:0] long_press,
    output logic [NUM_CH-1:0] toggled
);

    if (NUM_CH < 1 || NUM_CH > 16) begin : g_bad_ch
        $error("button_bank: NUM_CH must be in 1..16");
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        button_channel #(
            .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
            .LONG_PRESS_CYCLES(LONG_PRESS_CYCLES),
            .ACTIVE_LOW       (ACTIVE_LOW[i]),
            .TOGGLE           (TOGGLE_MASK[i])
        ) u_channel (
            .clk         (CLOCK_50),
            .reset       (reset),
            .pin         (buttons[i]),
            .clear_toggle(clear_toggle[i]),
            .level       (level[i]),
            .pressed     (pressed[i]),
            .released    (released[i]),
            .long_press  (long_press[i]),
            .toggled     (toggled[i])
        );
    end

endmodule

// File: tb/tb_button_bank.sv
// Directed bench for button_bank: DEBOUNCE=4, LONG_PRESS=20, 4 channels, ch0 active-low, ch1 toggles.
// Long-press expectations follow BUTTON_BANK_LONG_PRESS_EN as seen by this compile.
module tb_button_bank;

`ifdef BUTTON_BANK_LONG_PRESS_EN
    localparam bit LP_EN = 1'b1;
`else
    localparam bit LP_EN = 1'b0;
`endif

    logic       CLOCK_50;
    logic       reset;
    logic [3:0] buttons;
    logic [3:0] clear_toggle;
    logic [3:0] level;
    logic [3:0] pressed;
    logic [3:0] released;
    logic [3:0] long_press;
    logic [3:0] toggled;

    int         n_tests;
    int         n_fail;
    logic [3:0] exp_level;

    button_bank #(
        .NUM_CH           (4),
        .DEBOUNCE_CYCLES  (4),
        .LONG_PRESS_CYCLES(20),
        .ACTIVE_LOW       (4'b0001),
        .TOGGLE_MASK      (4'b0010)
    ) dut (
        .CLOCK_50    (CLOCK_50),
        .reset       (reset),
        .buttons     (buttons),
        .clear_toggle(clear_toggle),
        .level       (level),
        .pressed     (pressed),
        .released    (released),
        .long_press  (long_press),
        .toggled     (toggled)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic check(input string tag, input logic [3:0] observed, input logic [3:0] expected);
        n_tests++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, observed, expected);
        end
    endtask

    // Apply pins in cycle 0, watch 8 cycles; the event lands in cycle 6.
    // clear_toggle[1] is driven during cycle clr_cycle; toggled changes after cycle tog_sw.
    task automatic edge_window(input string tag, input logic [3:0] pins, input logic [3:0] evt,
                               input logic rising, input int clr_cycle, input int tog_sw,
                               input logic [3:0] tog_before, input logic [3:0] tog_after);
        logic [3:0] lvl_after;
        lvl_after = rising ? (exp_level | evt) : (exp_level & ~evt);
        buttons = pins;
        for (int k = 1; k <= 8; k++) begin
            tick();
            check($sformatf("%s pressed k=%0d", tag, k), pressed,
                  (rising && k == 6) ? evt : 4'b0000);
            check($sformatf("%s released k=%0d", tag, k), released,
                  (!rising && k == 6) ? evt : 4'b0000);
            check($sformatf("%s level k=%0d", tag, k), level, (k >= 6) ? lvl_after : exp_level);
            check($sformatf("%s toggled k=%0d", tag, k), toggled,
                  (k > tog_sw) ? tog_after : tog_before);
            check($sformatf("%s long_press k=%0d", tag, k), long_press, 4'b0000);
            clear_toggle = (k == clr_cycle) ? 4'b0010 : 4'b0000;
        end
        clear_toggle = 4'b0000;
        exp_level = lvl_after;
    endtask

    initial begin
        logic [15:0] bounce;
        n_tests      = 0;
        n_fail       = 0;
        exp_level    = 4'b0000;
        reset        = 1'b1;
        buttons      = 4'b0001;
        clear_toggle = 4'b0000;

        // Reset state
        repeat (3) tick();
        check("reset level", level, 4'b0000);
        check("reset pressed", pressed, 4'b0000);
        check("reset released", released, 4'b0000);
        check("reset long_press", long_press, 4'b0000);
        check("reset toggled", toggled, 4'b0000);
        reset = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            check($sformatf("idle level k=%0d", k), level, 4'b0000);
            check($sformatf("idle pressed k=%0d", k), pressed, 4'b0000);
        end

        // Clean press / release on ch1 (toggle channel)
        edge_window("clean_press", 4'b0011, 4'b0010, 1'b1, 0, 6, 4'b0000, 4'b0010);
        edge_window("clean_release", 4'b0001, 4'b0010, 1'b0, 0, 6, 4'b0010, 4'b0010);

        // Bounce on ch2: 3 high, 1 low, 3 high, then low
        bounce = 16'b0000_0000_0111_0111;
        for (int k = 0; k < 16; k++) begin
            buttons = {1'b0, bounce[k], 2'b01};
            tick();
            check($sformatf("bounce level k=%0d", k), level, exp_level);
            check($sformatf("bounce pressed k=%0d", k), pressed, 4'b0000);
        end
        buttons = 4'b0001;
        repeat (4) tick();

        // Long press on ch3: held 40 cycles
        buttons = 4'b1001;
        for (int k = 1; k <= 50; k++) begin
            tick();
            check($sformatf("long pressed k=%0d", k), pressed, (k == 6) ? 4'b1000 : 4'b0000);
            check($sformatf("long released k=%0d", k), released, (k == 46) ? 4'b1000 : 4'b0000);
            check($sformatf("long long_press k=%0d", k), long_press,
                  (LP_EN && k == 26) ? 4'b1000 : 4'b0000);
            check($sformatf("long level k=%0d", k), level,
                  (k >= 6 && k < 46) ? 4'b1000 : 4'b0000);
            if (k == 40) buttons = 4'b0001;
        end

        // Active-low ch0 and active-high ch1 pressed together
        edge_window("simul_press", 4'b0010, 4'b0011, 1'b1, 0, 6, 4'b0010, 4'b0000);
        edge_window("simul_release", 4'b0001, 4'b0011, 1'b0, 0, 6, 4'b0000, 4'b0000);

        // Clear coinciding with press keeps toggled at 0 from either starting value
        edge_window("clear_vs_press0", 4'b0011, 4'b0010, 1'b1, 6, 6, 4'b0000, 4'b0000);
        edge_window("rel_a", 4'b0001, 4'b0010, 1'b0, 0, 6, 4'b0000, 4'b0000);
        edge_window("press_b", 4'b0011, 4'b0010, 1'b1, 0, 6, 4'b0000, 4'b0010);
        edge_window("rel_b", 4'b0001, 4'b0010, 1'b0, 0, 6, 4'b0010, 4'b0010);
        edge_window("clear_race", 4'b0011, 4'b0010, 1'b1, 6, 6, 4'b0010, 4'b0000);
        edge_window("rel_c", 4'b0001, 4'b0010, 1'b0, 0, 6, 4'b0000, 4'b0000);
        edge_window("press_d", 4'b0011, 4'b0010, 1'b1, 0, 6, 4'b0000, 4'b0010);
        edge_window("rel_clear_d", 4'b0001, 4'b0010, 1'b0, 3, 3, 4'b0010, 4'b0000);
        edge_window("press_e", 4'b0011, 4'b0010, 1'b1, 0, 6, 4'b0000, 4'b0010);
        edge_window("rel_e", 4'b0001, 4'b0010, 1'b0, 0, 6, 4'b0010, 4'b0010);

        // Reset mid-hold on ch2, pin stays high
        buttons = 4'b0101;
        for (int k = 1; k <= 16; k++) begin
            tick();
            check($sformatf("hold pressed k=%0d", k), pressed, (k == 6) ? 4'b0100 : 4'b0000);
            check($sformatf("hold level k=%0d", k), level, (k >= 6) ? 4'b0100 : 4'b0000);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midreset level", level, 4'b0000);
        check("midreset pressed", pressed, 4'b0000);
        check("midreset released", released, 4'b0000);
        check("midreset long_press", long_press, 4'b0000);
        check("midreset toggled", toggled, 4'b0000);
        for (int k = 1; k <= 8; k++) begin
            tick();
            check($sformatf("after_reset pressed k=%0d", k), pressed, (k == 6) ? 4'b0100 : 4'b0000);
            check($sformatf("after_reset released k=%0d", k), released, 4'b0000);
            check($sformatf("after_reset level k=%0d", k), level, (k >= 6) ? 4'b0100 : 4'b0000);
        end
        exp_level = 4'b0100;
        edge_window("final_release", 4'b0001, 4'b0100, 1'b0, 0, 6, 4'b0000, 4'b0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
